// File: rtl/sram_pkg.sv
// sram_pkg: bus widths, wait-counter width and controller state type shared
// by the asynchronous SRAM controller and its bench.
package sram_pkg;

   localparam int SRAM_AW = 15;
   localparam int SRAM_DW = 8;
   localparam int CNT_W   = $clog2(16);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller issuing one access per
// request with a chip-enable pulse of WAIT_CYCLES cycles; every output is registered.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [SRAM_AW-1:0] req_addr,
   input  logic [SRAM_DW-1:0] req_wdata,
   output logic               rsp_valid,
   output logic [SRAM_DW-1:0] rsp_rdata,
   output logic [SRAM_AW-1:0] sram_a,
   output logic               sram_ce,
   output logic               sram_we,
   output logic               sram_oe,
   output logic [SRAM_DW-1:0] sram_data_o,
   input  logic [SRAM_DW-1:0] sram_data_i
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 write_q, write_d;
   logic [SRAM_AW-1:0]   addr_q, addr_d;
   logic [SRAM_DW-1:0]   wdata_q, wdata_d;
   logic [SRAM_DW-1:0]   rdata_q, rdata_d;
   logic                 ce_q, ce_d;
   logic                 we_q, we_d;
   logic                 oe_q, oe_d;
   logic                 ready_q, ready_d;
   logic                 rsp_valid_q, rsp_valid_d;

   // Next-state logic; strobes are derived from the next state so they leave flops.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               state_d = SETUP;
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!write_q) begin
                  rdata_d = sram_data_i;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // WE stays low through DONE so it can only rise once CE is already high.
      ce_d        = (state_d == ACCESS) ? 1'b0 : 1'b1;
      we_d        = (write_d && (state_d != IDLE)) ? 1'b0 : 1'b1;
      oe_d        = (!write_d && ((state_d == SETUP) || (state_d == ACCESS))) ? 1'b0 : 1'b1;
      ready_d     = (state_d == IDLE) ? 1'b1 : 1'b0;
      rsp_valid_d = (state_d == DONE) ? 1'b1 : 1'b0;
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         ce_q        <= 1'b1;
         we_q        <= 1'b1;
         oe_q        <= 1'b1;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         ce_q        <= ce_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign req_ready   = ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign sram_a      = addr_q;
   assign sram_data_o = wdata_q;
   assign sram_ce     = ce_q;
   assign sram_we     = we_q;
   assign sram_oe     = oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controllers (WAIT_CYCLES 2, 1, 15) each driving a small
// behavioural async SRAM, checked against a transaction-level memory model.
module tb_sram_ctrl;
   import sram_pkg::*;

   localparam int NI = 3;

   function automatic int wc_of(input int k);
      case (k)
         0:       wc_of = 2;
         1:       wc_of = 1;
         default: wc_of = 15;
      endcase
   endfunction

   logic                          clk = 1'b0;
   logic                          reset;
   logic [NI-1:0]                 req_valid, req_ready, req_write, rsp_valid;
   logic [NI-1:0]                 sram_ce, sram_we, sram_oe;
   logic [NI-1:0][SRAM_AW-1:0]    req_addr, sram_a;
   logic [NI-1:0][SRAM_DW-1:0]    req_wdata, rsp_rdata, sram_data_o, sram_data_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0]  ref_mem [int];
   logic [7:0]  last_rd [NI];
   int          prev_t [NI];
   bit          prev_keep [NI];
   bit          armed = 1'b0;
   logic        rst_q = 1'b1;
   logic [NI-1:0] ce_prev = '1, we_prev = '1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   for (genvar g = 0; g < NI; g++) begin : g_inst
      logic [7:0] mem [32768];

      sram_ctrl #(.WAIT_CYCLES(wc_of(g))) u_dut (
         .clk         (clk),
         .reset       (reset),
         .req_valid   (req_valid[g]),
         .req_ready   (req_ready[g]),
         .req_write   (req_write[g]),
         .req_addr    (req_addr[g]),
         .req_wdata   (req_wdata[g]),
         .rsp_valid   (rsp_valid[g]),
         .rsp_rdata   (rsp_rdata[g]),
         .sram_a      (sram_a[g]),
         .sram_ce     (sram_ce[g]),
         .sram_we     (sram_we[g]),
         .sram_oe     (sram_oe[g]),
         .sram_data_o (sram_data_o[g]),
         .sram_data_i (sram_data_i[g])
      );

      always @(posedge clk) begin
         if (!sram_ce[g] && !sram_we[g]) mem[sram_a[g]] <= sram_data_o[g];
      end

      assign sram_data_i[g] = (!sram_ce[g] && !sram_oe[g] && sram_we[g]) ? mem[sram_a[g]] : 8'h00;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Strobe-level protocol rules, every cycle on every instance.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (armed && !sram_oe[k]) chk("oe_low_needs_we_high", {31'd0, sram_we[k]}, 32'd1);
         if (armed && !rst_q && sram_we[k] && !we_prev[k])
            chk("we_rise_with_ce_high", {30'd0, ce_prev[k], sram_ce[k]}, 32'd3);
      end
      ce_prev <= sram_ce;
      we_prev <= sram_we;
   end

   // One complete request; entered and left at a falling edge.
   task automatic xact(input int k, input bit wr, input logic [14:0] addr,
                       input logic [7:0] wd, input bit keep);
      int t, n, low_cnt, ce_cnt, w, key;
      bit seen;
      logic [7:0] exp_rd;
      w   = wc_of(k);
      key = k * 32768 + int'(addr);
      req_write[k] = wr;
      req_addr[k]  = addr;
      req_wdata[k] = wd;
      req_valid[k] = 1'b1;
      n = 0;
      while (!req_ready[k] && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[k]) begin
         chk("handshake_timeout", 32'd0, 32'd1);
         req_valid[k] = 1'b0;
         return;
      end
      t = cyc;
      if (prev_keep[k]) chk("b2b_handshake_gap", 32'(t - prev_t[k]), 32'(3 + w));
      prev_t[k]    = t;
      prev_keep[k] = keep;
      low_cnt = 0;
      ce_cnt  = 0;
      seen    = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (keep) begin
            req_addr[k]  = 15'($urandom);
            req_wdata[k] = 8'($urandom);
            req_write[k] = 1'($urandom);
         end else begin
            req_valid[k] = 1'b0;
         end
         if (!req_ready[k]) low_cnt++;
         if (!sram_ce[k]) ce_cnt++;
         chk("sram_a_hold", 32'(sram_a[k]), 32'(addr));
         if (wr) chk("sram_dout_hold", 32'(sram_data_o[k]), 32'(wd));
         if (rsp_valid[k]) seen = 1'b1;
      end
      chk("rsp_seen", {31'd0, seen}, 32'd1);
      if (seen) begin
         chk("rsp_latency", 32'(cyc - t), 32'(2 + w));
         chk("ready_low_cycles", 32'(low_cnt), 32'(2 + w));
         chk("ce_low_cycles", 32'(ce_cnt), 32'(w));
         if (wr) begin
            ref_mem[key] = wd;
            chk("rdata_hold_on_write", 32'(rsp_rdata[k]), 32'(last_rd[k]));
         end else begin
            exp_rd = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
            chk("read_data", 32'(rsp_rdata[k]), 32'(exp_rd));
            last_rd[k] = exp_rd;
         end
      end
      @(negedge clk);
      chk("rsp_single_pulse", {31'd0, rsp_valid[k]}, 32'd0);
      chk("ready_after_done", {31'd0, req_ready[k]}, 32'd1);
      chk("rdata_hold_idle", 32'(rsp_rdata[k]), 32'(last_rd[k]));
   endtask

   // Start a request, then assert reset once the access phase has begun.
   task automatic abort_xact(input int k, input bit wr, input logic [14:0] addr, input logic [7:0] wd);
      int n;
      req_write[k] = wr;
      req_addr[k]  = addr;
      req_wdata[k] = wd;
      req_valid[k] = 1'b1;
      @(negedge clk);
      req_valid[k] = 1'b0;
      n = 0;
      while (sram_ce[k] && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_access", {31'd0, sram_ce[k]}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_strobes_idle", {29'd0, sram_ce[k], sram_we[k], sram_oe[k]}, 32'd7);
      chk("abort_no_rsp", {31'd0, rsp_valid[k]}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, req_ready[k]}, 32'd1);
      chk("no_rsp_after_reset", {31'd0, rsp_valid[k]}, 32'd0);
      chk("rdata_cleared", 32'(rsp_rdata[k]), 32'd0);
      for (int j = 0; j < NI; j++) begin
         last_rd[j]   = 8'h00;
         prev_keep[j] = 1'b0;
      end
      if (wr) ref_mem.delete(k * 32768 + int'(addr));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [14:0] pool [$];
      logic [14:0] ad;
      logic [7:0]  wd;
      int          r, nops;
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int k = 0; k < NI; k++) begin
         last_rd[k]   = 8'h00;
         prev_t[k]    = 0;
         prev_keep[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      armed = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready", {31'd0, req_ready[k]}, 32'd1);
         chk("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
         chk("rst_rdata", 32'(rsp_rdata[k]), 32'd0);
         chk("rst_strobes", {29'd0, sram_ce[k], sram_we[k], sram_oe[k]}, 32'd7);
         chk("rst_addr", 32'(sram_a[k]), 32'd0);
         chk("rst_dout", 32'(sram_data_o[k]), 32'd0);
      end

      xact(0, 1'b1, 15'h1234, 8'hA5, 1'b0);
      xact(0, 1'b0, 15'h1234, 8'h00, 1'b0);

      xact(0, 1'b1, 15'h0000, 8'h5C, 1'b1);
      xact(0, 1'b1, 15'h7FFF, 8'hC3, 1'b1);
      xact(0, 1'b0, 15'h0000, 8'h00, 1'b1);
      xact(0, 1'b0, 15'h7FFF, 8'h00, 1'b0);

      for (int k = 1; k < NI; k++) begin
         xact(k, 1'b1, 15'h2AAA, 8'h69, 1'b0);
         xact(k, 1'b0, 15'h2AAA, 8'h00, 1'b0);
      end

      for (int k = 0; k < NI; k++) begin
         pool.delete();
         nops = (k == 2) ? 12 : 30;
         for (int i = 0; i < nops; i++) begin
            r = $urandom_range(0, 7);
            if (pool.size() == 0 || r < 4) begin
               ad = (r == 0) ? 15'h0000 : (r == 1) ? 15'h7FFF : 15'($urandom);
               if (pool.size() != 0 && r == 3) ad = pool[$urandom_range(0, pool.size() - 1)];
               wd = 8'($urandom);
               pool.push_back(ad);
               xact(k, 1'b1, ad, wd, (i != nops - 1) ? 1'($urandom) : 1'b0);
            end else begin
               ad = pool[$urandom_range(0, pool.size() - 1)];
               xact(k, 1'b0, ad, 8'h00, (i != nops - 1) ? 1'($urandom) : 1'b0);
            end
         end
      end

      abort_xact(0, 1'b0, 15'h1234, 8'h00);
      xact(0, 1'b1, 15'h0100, 8'h3C, 1'b0);
      abort_xact(0, 1'b1, 15'h0101, 8'h77);
      xact(0, 1'b0, 15'h0100, 8'h00, 1'b0);
      xact(0, 1'b0, 15'h7FFF, 8'h00, 1'b0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of cycles CE stays low per access; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1=write, 0=read.
REQ-007 SHALL have port req_addr  input  15  byte address.
REQ-008 SHALL have port req_wdata  input  8  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse, reads and writes.
REQ-010 SHALL have port rsp_rdata  output  8  read data, valid with rsp_valid on reads.
REQ-011 SHALL have port sram_a  output  15  SRAM address.
REQ-012 SHALL have port sram_ce  output  1  SRAM chip enable, active low.
REQ-013 SHALL have port sram_we  output  1  SRAM write enable, active low.
REQ-014 SHALL have port sram_oe  output  1  SRAM output enable, active low.
REQ-015 SHALL have port sram_data_o  output  8  data driven to SRAM data_i.
REQ-016 SHALL have port sram_data_i  input  8  data from SRAM data_o (may be Z when not enabled).

Function
REQ-017 All outputs SHALL be registered; no combinational path from req_* to sram_*.
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready, request latched (addr, wdata, write) that cycle.
REQ-020 IDLE -> SETUP on handshake; SETUP -> ACCESS after 1 cycle; ACCESS -> DONE after exactly WAIT_CYCLES cycles; DONE -> IDLE after 1 cycle.
REQ-021 sram_a and sram_data_o SHALL hold the latched values from SETUP through DONE inclusive, unchanged.
REQ-022 Read: SETUP ce=1 oe=0 we=1; ACCESS ce=0 oe=0 we=1; DONE ce=1 oe=1 we=1.
REQ-023 Read: sram_data_i SHALL be sampled on the last ACCESS cycle and presented on rsp_rdata in DONE.
REQ-024 Write: SETUP ce=1 we=0 oe=1; ACCESS ce=0 we=0 oe=1; DONE ce=1 we=0 oe=1; we returns to 1 in IDLE, so WE never rises before CE.
REQ-025 oe SHALL never be 0 while we is 0.
REQ-026 rsp_valid SHALL be 1 exactly in DONE, for one cycle per request.
REQ-027 rsp_rdata SHALL hold its last read value on writes and in idle.
REQ-028 Latency: handshake at cycle T -> rsp_valid at T+2+WAIT_CYCLES; next handshake no earlier than T+3+WAIT_CYCLES.
REQ-029 Wait counter SHALL load WAIT_CYCLES-1 on SETUP->ACCESS and decrement to 0; width $clog2(16).
REQ-030 req_valid deasserted or changed outside IDLE SHALL be ignored.

Reset
REQ-031 reset SHALL take priority over all transitions and force state IDLE next cycle.
REQ-032 Reset values: req_ready=1 (after reset deasserts), rsp_valid=0, rsp_rdata=0, sram_ce=1, sram_we=1, sram_oe=1, sram_a=0, sram_data_o=0, counter=0.
REQ-033 Reset mid-operation SHALL abort with no rsp_valid; contents of the aborted write location are unspecified, all other locations untouched.

Structure
REQ-034 Package sram_pkg SHALL hold SRAM_AW=15, SRAM_DW=8 and the state enum type.
REQ-035 No sub-module; single module with FSM plus counter.

Verification (bench instantiates sram_ctrl with a cy7c199 as SRAM)
REQ-036 Write 0x1234<-0xA5 then read 0x1234 -> rsp_rdata=0xA5, rsp_valid at T+4 each (WAIT_CYCLES=2).
REQ-037 Back-to-back requests with req_valid held high -> req_ready low for 4 cycles per request, writes to 0x0000 and 0x7FFF then reads return written values.
REQ-038 Checker every cycle: oe=0 implies we=1; we rises only when ce=1; sram_a stable SETUP..DONE.
REQ-039 WAIT_CYCLES=1 and 15 -> rsp_valid at T+3 and T+17; data correct.
REQ-040 reset asserted during ACCESS of a read -> next cycle ce=we=oe=1, no rsp_valid, req_ready=1 after reset released.
REQ-041 Write 0x0100<-0x3C, reset during a write to 0x0101 -> read 0x0100 returns 0x3C.
